// File: rtl/stream_demux_n.sv
// N-channel Avalon-ST packet demultiplexer: steers each packet to the lowest-index
// channel whose enabled EtherType matches at SOP, drops unmatched packets, counts events.
module stream_demux_n #(
  parameter int DW     = 512,
  parameter int EW     = 6,
  parameter int NCH    = 3,
  parameter int ET_LSB = 400,
  parameter int CW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [EW-1:0]     in_empty,
  output logic              in_ready,
  input  logic [NCH*16-1:0] cfg_eth_type,
  input  logic [NCH-1:0]    cfg_ch_en,
  output logic [DW-1:0]     out_data,
  output logic [NCH-1:0]    out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [EW-1:0]     out_empty,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*CW-1:0] stat_pkt_cnt,
  output logic [CW-1:0]     stat_drop_cnt,
  output logic [CW-1:0]     stat_err_cnt
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;

  logic [DW-1:0]   out_data_q;
  logic [NCH-1:0]  out_valid_q;
  logic            out_sop_q, out_eop_q;
  logic [EW-1:0]   out_empty_q;

  logic [CW-1:0]   pkt_cnt_q [NCH];
  logic [CW-1:0]   drop_cnt_q, err_cnt_q;

  logic [15:0]     eth_type;
  logic            hit_any;
  logic [SW-1:0]   hit_idx;
  logic            slot_free, accept, fwd_go;
  logic            pkt_inc, drop_inc, err_inc;
  logic [SW-1:0]   fwd_ch;
  logic [NCH-1:0]  fwd_onehot;

  assign eth_type = in_data[ET_LSB +: 16];

  // Descending scan so the lowest matching index is the last writer and wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cfg_ch_en[i] && (cfg_eth_type[16*i +: 16] == eth_type)) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign slot_free = ~(|out_valid_q) | (|(out_valid_q & out_ready));

  // in_ready never looks at in_valid; only matched SOPs and FWD beats need the slot.
  always_comb begin
    in_ready = 1'b1;
    unique case (state_q)
      IDLE:    if (in_sop && hit_any) in_ready = slot_free;
      FWD:     in_ready = slot_free;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign pkt_inc  = accept & (state_q == IDLE) & in_sop & hit_any;
  assign drop_inc = in_valid & (state_q == IDLE) & in_sop & ~hit_any;
  assign err_inc  = in_valid & (state_q == IDLE) & ~in_sop;
  assign fwd_go   = pkt_inc | (accept & (state_q == FWD));
  assign fwd_ch   = (state_q == FWD) ? sel_q : hit_idx;

  always_comb begin
    fwd_onehot = '0;
    for (int i = 0; i < NCH; i++) fwd_onehot[i] = (fwd_ch == SW'(i));
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_inc && !in_eop) begin
          state_d = FWD;
          sel_d   = hit_idx;
        end else if (drop_inc && !in_eop) begin
          state_d = DROP;
        end
      end
      FWD:     if (accept && in_eop) state_d = IDLE;
      DROP:    if (in_valid && in_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
      for (int i = 0; i < NCH; i++) pkt_cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (fwd_go) begin
        out_valid_q <= fwd_onehot;
        out_data_q  <= in_data;
        out_sop_q   <= in_sop;
        out_eop_q   <= in_eop;
        out_empty_q <= in_empty;
      end else if (slot_free) begin
        out_valid_q <= '0;
      end
      if (drop_inc) drop_cnt_q <= drop_cnt_q + CW'(1);
      if (err_inc)  err_cnt_q  <= err_cnt_q + CW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (pkt_inc && (hit_idx == SW'(i))) pkt_cnt_q[i] <= pkt_cnt_q[i] + CW'(1);
      end
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_sop       = out_sop_q;
  assign out_eop       = out_eop_q;
  assign out_empty     = out_empty_q;
  assign stat_drop_cnt = drop_cnt_q;
  assign stat_err_cnt  = err_cnt_q;

  always_comb begin
    stat_pkt_cnt = '0;
    for (int i = 0; i < NCH; i++) stat_pkt_cnt[i*CW +: CW] = pkt_cnt_q[i];
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised N-channel packet demultiplexer for the 512-bit Avalon-ST datapath. It sits after the ingress MAC stream and before the per-class consumers (packet buffer, metadata FIFO, user-data path). Each packet is steered to one channel by matching its EtherType at SOP against a runtime-programmable per-channel table. Unmatched packets are dropped and counted. Handshake is true valid/ready with a one-deep registered output stage.

## Interface
Parameters:
- DW, 512, data width in bits.
- EW, 6, empty-field width; must equal log2(DW/8).
- NCH, 3, number of output channels (1..8).
- ET_LSB, 400, bit position of EtherType LSB in the SOP beat; EtherType = in_data[ET_LSB+15:ET_LSB].
- CW, 32, statistics counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DW  input beat.
- in_valid  in  1  input beat valid.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_empty  in  EW  empty bytes on EOP beat.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- cfg_eth_type  in  NCH*16  EtherType for channel i at [16i+15:16i].
- cfg_ch_en  in  NCH  channel i participates in matching.
- out_data  out  DW  shared output data.
- out_valid  out  NCH  one-hot (or zero) per-channel valid.
- out_sop, out_eop  out  1 each  shared framing.
- out_empty  out  EW  shared empty.
- out_ready  in  NCH  per-channel ready.
- stat_pkt_cnt  out  NCH*CW  packets forwarded per channel.
- stat_drop_cnt  out  CW  unmatched packets dropped.
- stat_err_cnt  out  CW  non-SOP beats received in IDLE.

## Operation
- States: IDLE, FWD (with registered channel index sel), DROP.
- Match (IDLE, in_valid & in_sop): hit[i] = cfg_ch_en[i] & (EtherType == cfg_eth_type[16i+15:16i]). Lowest-index hit wins. cfg is sampled only at SOP; changes mid-packet do not affect the current packet.
- IDLE, SOP, hit on ch:
  - Beat is accepted when the ch slot is free.
  - If !in_eop, go to FWD with sel=ch.
  - If in_eop, stay in IDLE.
  - stat_pkt_cnt[ch]++ when the SOP beat is accepted.
- IDLE, SOP, no hit:
  - in_ready=1 and the beat is consumed.
  - stat_drop_cnt++.
  - If !in_eop, go to DROP.
- IDLE, in_valid & !in_sop: beat consumed, stat_err_cnt++, state unchanged.
- FWD: all beats go to sel. SOP and EtherType are not re-examined. An accepted EOP beat returns to IDLE. An SOP arriving while in FWD is forwarded as data (no resync).
- DROP: in_ready=1 and beats are discarded. An accepted EOP beat returns to IDLE.
- Output stage: one register shared by all channels; at most one out_valid bit is set.
  - The slot is free when out_valid==0, or (out_valid[k] & out_ready[k]) for the k currently held.
  - In IDLE with a hit, in_ready = slot free. In FWD, in_ready = slot free.
  - Head-of-line blocking is intended: a stalled channel blocks all input.
- Counters wrap modulo 2^CW. Simultaneous events in one cycle each increment their own counter.
- Reset:
  - State = IDLE. out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0. All counters = 0.
  - Reset mid-packet abandons the packet. The next non-SOP beats are counted as err.

## Timing
- Latency: an accepted input beat appears on out_* in the next cycle.
- Full throughput: 1 beat/cycle when the target out_ready is held high.
- in_ready is combinational from state, in_data (EtherType), in_sop, cfg_*, out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- out_* are held stable while out_valid[k] & !out_ready[k].
- Counters update the cycle after the counted acceptance.
- After an EOP beat is accepted, a back-to-back SOP on the next cycle is matched with no bubble.

## Test plan
- cfg = {0x0800, 0x88B5, 0x88B6}, all enabled. Send a 4-beat packet with EtherType 0x0800 and out_ready=3'b111 -> 4 beats on out_valid=3'b001 at cycles t+1..t+4, sop on the first, eop with empty=12 on the last. stat_pkt_cnt[0]=1.
- Single-beat SOP+EOP with EtherType 0x88B5 -> one beat on channel 1 with sop=eop=1. State remains IDLE. The following back-to-back packet to ch2 is forwarded with no idle cycle.
- EtherType 0x86DD, 3 beats -> no out_valid. in_ready=1 throughout. stat_drop_cnt=1.
- Channel 0 forwarding with out_ready[0] deasserted for 5 cycles mid-packet -> in_ready=0 for those cycles, out_* held stable, no beat lost or duplicated. Data checked against a scoreboard.
- Two channels both programmed 0x0800 -> lowest index wins (ch0 receives). With cfg_ch_en[0]=0 -> ch1 receives.
- Assert rst during beat 2 of 4. Then send 2 orphan beats followed by a new packet -> outputs 0 during reset, stat_err_cnt=2, new packet forwarded correctly. Counter preloaded near max (force 2^CW-1) wraps to 0.
